multu_seq_ctrl: RTL and testbench
=================================

# multu_seq_ctrl

Sequential controller for the MIPS pipeline CPU's MULTU/MFHI/MFLO path. It replaces a single-cycle 32x32 multiplier with a radix-2 shift-add unit and owns the HI/LO registers. It sits beside the EX stage:
- accepts a MULTU issue from EX;
- iterates for a fixed number of cycles;
- raises a pipeline stall toward the hazard unit while a dependent MFHI/MFLO, or a second MULTU, tries to proceed before the product is written.

## Interface
Parameters
- WIDTH, 32, operand width; product is 2*WIDTH bits split into HI/LO; legal values ≥ 2.

Ports
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately when low.
- start  in  1  EX stage holds a MULTU this cycle.
- src_a  in  WIDTH  multiplicand (rs value, post-forwarding).
- src_b  in  WIDTH  multiplier (rt value, post-forwarding).
- rd_hi  in  1  ID/EX holds an MFHI this cycle.
- rd_lo  in  1  ID/EX holds an MFLO this cycle.
- busy  out  1  multiply in progress (state RUN).
- stall  out  1  freeze PC, IF/ID, ID/EX; bubble into EX/MEM.
- done  out  1  one-cycle pulse: HI/LO were just written.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: waiting for a MULTU.
  - RUN: iterating.
- IDLE:
  - start=1 → latch src_a into mcand, src_b into mplier.
  - Clear the accumulator acc (WIDTH+1 bits) and set count=0.
  - Go to RUN.
  - start is only honoured in IDLE.
- RUN, each edge:
  - sum = acc + (mplier[0] ? mcand : 0), computed at WIDTH+1 bits.
  - {acc, mplier} ← {sum, mplier} >> 1, a logical right shift of the 2*WIDTH+1-bit concatenation.
  - count ← count+1.
- RUN, iteration with count = WIDTH-1:
  - Write the final {acc[WIDTH-1:0], mplier} to hi/lo; the written value is the post-shift result.
  - Go to IDLE and set done=1 for the next cycle.
- Latency is fixed at WIDTH iterations regardless of operand values; there is no early-out on zero.
- stall = busy & (start | rd_hi | rd_lo), purely combinational.
  - A stalled MULTU is not lost: the pipeline re-presents it, and it is accepted on the first IDLE cycle.
  - While stall=1, start is not sampled.
- hi/lo change only at the completing edge. An MFHI/MFLO reads hi/lo directly with no internal forwarding, because the stall guarantees ordering.
- Reset (rst=0, at any time, including mid-RUN):
  - state=IDLE, busy=0, done=0, stall=0, hi=0, lo=0, acc/mplier/mcand/count=0.
  - An in-flight multiply is discarded with no partial write.

## Timing
- Edge E0 samples start=1 in IDLE; busy=1 from after E0.
- Edges E1..E_WIDTH perform the iterations.
- At E_WIDTH: hi/lo are updated, busy→0, and done=1 for exactly one cycle.
- An MFHI/MFLO stalled during RUN proceeds in the cycle after E_WIDTH and reads the new value.
- An MFHI in the done cycle sees no stall and the updated hi.
- Back-to-back MULTU: the second start is accepted at the edge after E_WIDTH, i.e. the earliest issue spacing is WIDTH+1 cycles. Its result overwrites hi/lo WIDTH edges later.
- start and rd_hi both high while busy: a single stall, with no priority issue.
- With stall=0 and no start, outputs are stable.
- Reset deassertion: the first active edge behaves as IDLE.

## Test plan
- **Basic product:** rst low for 1 cycle, then start with src_a=3, src_b=5.
  - busy high for exactly 32 cycles.
  - done pulses once.
  - hi=0x00000000, lo=0x0000000F.
- **Max operands:** src_a=src_b=0xFFFFFFFF.
  - hi=0xFFFFFFFE, lo=0x00000001 after 32 iterations.
  - Also 0x80000000 × 2 → hi=0x00000001, lo=0x00000000.
- **MFHI interlock:** MULTU 0x10000 × 0x10000, then rd_hi=1 from the next cycle.
  - stall=1 for all remaining RUN cycles.
  - stall=0 in the done cycle, with hi=0x00000001, lo=0.
- **Second MULTU while busy:** start held high during RUN with new operands 7×6.
  - stall=1 and the first result is unaffected.
  - Accepted on the first IDLE cycle; after 32 more cycles, lo=42, hi=0.
- **Reset mid-operation:** start 9×9, drop rst at iteration 10.
  - hi=lo=0, busy=0, stall=0 immediately (asynchronous, before the next edge).
  - No done pulse.
  - A subsequent 2×2 gives lo=4.
- **Zero operand and parameter sweep:** 0 × 0x12345678 still takes 32 cycles, giving hi=lo=0.
  - Repeat the basic product with WIDTH=8: 0xFF × 0xFF → hi=0xFE, lo=0x01, busy for 8 cycles.

Source files
------------

// File: rtl/multu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multu_seq_ctrl_if
//  Description : EX-stage <-> MULTU controller signal bundle
//  Revision    : 1.0  initial release
// ============================================================================
interface multu_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             rd_hi;
    logic             rd_lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues MULTU / MFHI / MFLO and observes the interlock.
    modport master (
        output start, src_a, src_b, rd_hi, rd_lo,
        input  busy, stall, done, hi, lo
    );

    // Controller side.
    modport slave (
        input  start, src_a, src_b, rd_hi, rd_lo,
        output busy, stall, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/multu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multu_seq_ctrl
//  Description : Radix-2 shift-add MULTU unit owning HI/LO, with MFHI/MFLO
//                and back-to-back MULTU interlock toward the hazard unit.
//  Revision    : 1.0  initial release
// ============================================================================
module multu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    multu_seq_ctrl_if.slave     bus
);
    localparam int             c_CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST_ITER = c_CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH:0]     r_acc;
    logic [c_CW-1:0]    r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_busy;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_shift;

    assign w_busy   = (r_state == S_RUN);
    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = w_busy && (r_count == c_LAST_ITER);

    // One radix-2 step: conditional add, then shift the whole {acc,mplier} pair.
    assign w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = r_acc + w_addend;
    assign w_shift  = {w_sum, r_mplier} >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (r_count == c_LAST_ITER) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mcand  <= bus.src_a;
                r_mplier <= bus.src_b;
                r_acc    <= '0;
                r_count  <= '0;
            end else if (w_busy) begin
                r_acc    <= w_shift[2*WIDTH:WIDTH];
                r_mplier <= w_shift[WIDTH-1:0];
                r_count  <= r_count + c_CW'(1);
                // HI/LO only move on the completing edge; readers rely on the stall.
                if (w_last) begin
                    r_hi   <= w_shift[2*WIDTH-1:WIDTH];
                    r_lo   <= w_shift[WIDTH-1:0];
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.busy  = w_busy;
    assign bus.stall = w_busy & (bus.start | bus.rd_hi | bus.rd_lo);
    assign bus.done  = r_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_multu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multu_seq_ctrl
//  Description : Scoreboard bench for multu_seq_ctrl (WIDTH=32 and WIDTH=8)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multu_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multu_seq_ctrl_if #(.WIDTH(32)) b32();
    multu_seq_ctrl_if #(.WIDTH(8))  b8();

    multu_seq_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    multu_seq_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] q32[$];
    logic [15:0] q8[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitors: every done pulse must match the oldest pending product.
    always @(negedge clk) begin
        if (b32.done === 1'b1) begin
            if (q32.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL done32_unexpected: got hi=%h lo=%h expected no done", b32.hi, b32.lo);
            end else begin
                chk("result32", {b32.hi, b32.lo}, q32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (b8.done === 1'b1) begin
            if (q8.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL done8_unexpected: got hi=%h lo=%h expected no done", b8.hi, b8.lo);
            end else begin
                chk("result8", {48'd0, b8.hi, b8.lo}, {48'd0, q8.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] e, input bit push);
        int g;
        g = 0;
        while (b32.busy && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 200) chk("idle_timeout32", 64'd1, 64'd0);
        @(negedge clk);
        b32.start = 1'b1; b32.src_a = a; b32.src_b = b;
        if (push) q32.push_back(e);
        @(posedge clk); #1;
        b32.start = 1'b0;
    endtask

    task automatic busy_len32(input string name);
        int c;
        c = 0;
        while (b32.busy && c < 200) begin
            c++; @(posedge clk); #1;
        end
        chk(name, 64'(c), 64'd32);
    endtask

    initial begin
        int c;
        b32.start = 0; b32.src_a = 0; b32.src_b = 0; b32.rd_hi = 0; b32.rd_lo = 0;
        b8.start  = 0; b8.src_a  = 0; b8.src_b  = 0; b8.rd_hi  = 0; b8.rd_lo  = 0;

        // Reset state
        @(negedge clk);
        chk("rst_busy",  64'(b32.busy),  64'd0);
        chk("rst_stall", 64'(b32.stall), 64'd0);
        chk("rst_done",  64'(b32.done),  64'd0);
        chk("rst_hilo",  {b32.hi, b32.lo}, 64'd0);
        @(posedge clk); #2 rst = 1'b1;

        // Basic product and max operands
        issue32(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        busy_len32("busy_cycles_3x5");
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        busy_len32("busy_cycles_max");
        issue32(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);
        busy_len32("busy_cycles_msb");

        // MFHI interlock
        issue32(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
        b32.rd_hi = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("stall_mfhi_run", 64'(b32.stall), 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("stall_mfhi_done", 64'(b32.stall), 64'd0);
        chk("done_mfhi",       64'(b32.done),  64'd1);
        chk("hi_mfhi",         64'(b32.hi),    64'd1);
        chk("lo_mfhi",         64'(b32.lo),    64'd0);
        b32.rd_hi = 1'b0;

        // Second MULTU presented while busy
        @(negedge clk);
        b32.start = 1'b1; b32.src_a = 32'hFFFF_FFFF; b32.src_b = 32'hFFFF_FFFF;
        q32.push_back(64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;
        b32.src_a = 32'd7; b32.src_b = 32'd6;
        q32.push_back(64'd42);
        c = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (b32.stall === 1'b1) c++;
            @(posedge clk);
        end
        chk("stall_cycles_2nd", 64'(c), 64'd32);
        @(negedge clk);
        chk("stall_2nd_idle", {62'd0, b32.stall, b32.busy}, 64'd0);
        @(posedge clk); #1;
        b32.start = 1'b0;
        busy_len32("busy_cycles_7x6");

        // Asynchronous reset mid-operation
        issue32(32'd9, 32'd9, 64'd0, 1'b0);
        b32.rd_hi = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_hilo",  {b32.hi, b32.lo}, 64'd0);
        chk("arst_busy",  64'(b32.busy),  64'd0);
        chk("arst_stall", 64'(b32.stall), 64'd0);
        b32.rd_hi = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_done_hilo", {b32.hi, b32.lo}, 64'd0);

        issue32(32'd2, 32'd2, 64'd4, 1'b1);
        busy_len32("busy_cycles_2x2");

        // Zero operand: no early-out
        issue32(32'd0, 32'h1234_5678, 64'd0, 1'b1);
        busy_len32("busy_cycles_zero");

        // WIDTH=8 instance
        @(negedge clk);
        b8.start = 1'b1; b8.src_a = 8'hFF; b8.src_b = 8'hFF;
        q8.push_back(16'hFE01);
        @(posedge clk); #1;
        b8.start = 1'b0;
        c = 0;
        while (b8.busy && c < 100) begin
            c++; @(posedge clk); #1;
        end
        chk("busy_cycles8", 64'(c), 64'd8);

        repeat (4) @(posedge clk);
        #1;
        chk("pending32", 64'(q32.size()), 64'd0);
        chk("pending8",  64'(q8.size()),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
